// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared defaults (LeNet S2/S4 map sizes, pixel width) and counter-width helper
package pool_pkg;

  localparam int DATA_W_DEF = 16;

  localparam int S2_IMG_W = 28;
  localparam int S2_IMG_H = 28;
  localparam int S4_IMG_W = 10;
  localparam int S4_IMG_H = 10;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// rtl/pool_line_buf.sv - one-row pixel store: single write port, two combinational read ports
module pool_line_buf
  import pool_pkg::*;
#(
  parameter int DEPTH  = S2_IMG_W,
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  // Contents are fully rewritten by every even row, so no reset is needed.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/pool_window_gen.sv
// rtl/pool_window_gen.sv - raster pixel stream to non-overlapping 2x2 pooling windows
// Optional frame_done pulse enabled by defining POOL_WINDOW_FRAME_DONE_EN.
module pool_window_gen
  import pool_pkg::*;
#(
  parameter int IMG_W  = S2_IMG_W,
  parameter int IMG_H  = S2_IMG_H,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] numA,
  output logic [DATA_W-1:0] numB,
  output logic [DATA_W-1:0] numC,
  output logic [DATA_W-1:0] numD
`ifdef POOL_WINDOW_FRAME_DONE_EN
  ,
  output logic              frame_done
`endif
);

  if ((IMG_W < 2) || ((IMG_W % 2) != 0)) begin : g_bad_img_w
    $error("pool_window_gen: IMG_W must be even and >= 2");
  end
  if ((IMG_H < 2) || ((IMG_H % 2) != 0)) begin : g_bad_img_h
    $error("pool_window_gen: IMG_H must be even and >= 2");
  end

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col_even;
  logic              in_xfer;
  logic              col_wrap;
  logic              row_wrap;
  logic              odd_row;
  logic              odd_col;
  logic              lb_wr;
  logic              win_load;
  logic [DATA_W-1:0] left_px;
  logic [DATA_W-1:0] lb_top_left;
  logic [DATA_W-1:0] lb_top_right;

  // Only a window that is presented and refused may hold back the input.
  assign in_ready = !(out_valid && !out_ready);
  assign in_xfer  = in_valid && in_ready;

  assign odd_row  = row[0];
  assign odd_col  = col[0];
  assign col_wrap = (col == COL_LAST);
  assign row_wrap = (row == ROW_LAST);
  assign col_even = col & ~CW'(1);
  assign lb_wr    = in_xfer && !odd_row;
  assign win_load = in_xfer && odd_row && odd_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (in_xfer) begin
      if (col_wrap) begin
        col <= '0;
        row <= row_wrap ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  pool_line_buf #(
    .DEPTH (IMG_W),
    .DATA_W(DATA_W),
    .AW    (CW)
  ) u_line_buf (
    .clk      (clk),
    .wr_en    (lb_wr),
    .wr_addr  (col),
    .wr_data  (in_data),
    .rd_addr_a(col_even),
    .rd_data_a(lb_top_left),
    .rd_addr_b(col),
    .rd_data_b(lb_top_right)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_px <= '0;
    end else if (in_xfer && odd_row && !odd_col) begin
      left_px <= in_data;
    end
  end

  // A new window may replace the one being consumed in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      numA      <= '0;
      numB      <= '0;
      numC      <= '0;
      numD      <= '0;
    end else if (win_load) begin
      out_valid <= 1'b1;
      numA      <= lb_top_left;
      numB      <= lb_top_right;
      numC      <= left_px;
      numD      <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef POOL_WINDOW_FRAME_DONE_EN
  logic win_last;

  assign win_last = win_load && row_wrap && col_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= win_last;
    end
  end
`endif

endmodule

// File: tb/tb_pool_window_gen.sv
// tb/tb_pool_window_gen.sv - scoreboard bench: 4x4 directed frames with stalls/reset, plus a default 28x28 frame
module tb_pool_window_gen;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, numA, numB, numC, numD;

  logic          in_valid28, in_ready28, out_valid28, out_ready28;
  logic [DW-1:0] in_data28, a28, b28, c28, d28;

`ifdef POOL_WINDOW_FRAME_DONE_EN
  logic frame_done, frame_done28;
  int   fd_count = 0;
`endif

  int            checks = 0;
  int            errors = 0;
  logic [63:0]   exp_q[$];
  logic [63:0]   exp28_q[$];
  int            win4 = 0;
  int            win28 = 0;
  int            stall28 = 0;
  logic [DW-1:0] last_d28 = '0;

  // Pixel indices of each 4x4 window: top-left, top-right, bottom-left, bottom-right.
  int win_idx[4][4] = '{'{0, 1, 4, 5}, '{2, 3, 6, 7}, '{8, 9, 12, 13}, '{10, 11, 14, 15}};

  pool_window_gen #(.IMG_W(4), .IMG_H(4), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .numA(numA), .numB(numB), .numC(numC), .numD(numD)
`ifdef POOL_WINDOW_FRAME_DONE_EN
    , .frame_done(frame_done)
`endif
  );

  pool_window_gen dut28 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid28), .in_ready(in_ready28), .in_data(in_data28),
    .out_valid(out_valid28), .out_ready(out_ready28),
    .numA(a28), .numB(b28), .numC(c28), .numD(d28)
`ifdef POOL_WINDOW_FRAME_DONE_EN
    , .frame_done(frame_done28)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pv(input logic [DW-1:0] base, input int i);
    return base + DW'(i * 'h200);
  endfunction

  function automatic logic [63:0] win_of(input logic [DW-1:0] base, input int w);
    return {pv(base, win_idx[w][0]), pv(base, win_idx[w][1]),
            pv(base, win_idx[w][2]), pv(base, win_idx[w][3])};
  endfunction

  // Monitor for the 4x4 instance: pops on every output transfer.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      win4++;
      if (exp_q.size() == 0) chk("window_unexpected", 64'd0, 64'd1);
      else chk("window", {numA, numB, numC, numD}, exp_q.pop_front());
    end
`ifdef POOL_WINDOW_FRAME_DONE_EN
    if (rst_n && frame_done) begin
      fd_count++;
      chk("frame_done_with_valid", {63'd0, out_valid}, 64'd1);
    end
`endif
  end

  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid28 && out_ready28) begin
      win28++;
      last_d28 = d28;
      if (exp28_q.size() == 0) chk("window28_unexpected", 64'd0, 64'd1);
      else chk("window28", {a28, b28, c28, d28}, exp28_q.pop_front());
    end
  end

  task automatic send_px(input logic [DW-1:0] d, input int gap);
    int tmo;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = DW'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    #1;
    tmo = 0;
    while (!in_ready && tmo < 200) begin
      @(negedge clk);
      #1;
      tmo++;
    end
    if (tmo >= 200) chk("in_ready_timeout", 64'(tmo), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = DW'($urandom);
  endtask

  task automatic send_range(input logic [DW-1:0] base, input int first, input int last,
                            input int max_gap, input bit do_push);
    for (int i = first; i <= last; i++) begin
      int k;
      k = -1;
      for (int w = 0; w < 4; w++) if (win_idx[w][3] == i) k = w;
      if (do_push && k >= 0) exp_q.push_back(win_of(base, k));
      send_px(pv(base, i), (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
      if (do_push && k >= 0)
        chk("latency_one_cycle", {47'd0, out_valid, numD}, {47'd0, 1'b1, pv(base, i)});
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || exp28_q.size() != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain4", 64'(exp_q.size()), 64'd0);
    chk("drain28", 64'(exp28_q.size()), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid28 = 1'b0; in_data28 = '0; out_ready28 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_window", {numA, numB, numC, numD}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain 4x4 frame, always ready.
    chk("first_window_literal", win_of(16'h4000, 0), 64'h4000_4200_4800_4A00);
    send_range(16'h4000, 0, 15, 0, 1);
    drain();

    // Stall after the first window, then release.
    send_range(16'h4000, 0, 5, 0, 1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = pv(16'h4000, 6);
    #1;
    chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    repeat (3) begin
      chk("stall_hold", {numA, numB, numC, numD}, 64'h4000_4200_4800_4A00);
      chk("stall_valid", {63'd0, out_valid}, 64'd1);
      @(negedge clk);
      #1;
    end
    out_ready = 1'b1;
    send_range(16'h4000, 6, 15, 0, 1);
    drain();

    // Two frames with random input gaps, distinct pixel sets.
`ifdef POOL_WINDOW_FRAME_DONE_EN
    fd_count = 0;
`endif
    send_range(16'h4000, 0, 15, 3, 1);
    send_range(16'h6000, 0, 15, 3, 1);
    drain();
`ifdef POOL_WINDOW_FRAME_DONE_EN
    chk("frame_done_count", 64'(fd_count), 64'd2);
`endif

    // Reset mid-frame with a window pending; it must be discarded.
    out_ready = 1'b0;
    send_range(16'h1000, 0, 5, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midreset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midreset_window", {numA, numB, numC, numD}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    send_range(16'h8000, 0, 15, 0, 1);
    drain();
    chk("window_count4", 64'(win4), 64'd20);

    // Full default-size frame on the 28x28 instance.
    for (int i = 0; i < 784; i++) begin
      if (((i / 28) % 2 == 1) && ((i % 28) % 2 == 1))
        exp28_q.push_back({DW'(i - 29), DW'(i - 28), DW'(i - 1), DW'(i)});
      in_valid28 = 1'b1;
      in_data28  = DW'(i);
      #1;
      if (!in_ready28) stall28++;
      @(negedge clk);
    end
    in_valid28 = 1'b0;
    drain();
    chk("window_count28", 64'(win28), 64'd196);
    chk("stall_count28", 64'(stall28), 64'd0);
    chk("last_numD28", 64'(last_d28), 64'd783);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
